// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: issues a PC to synchronous instruction memory, captures the word,
// holds it until accepted downstream, and handles redirects, wraparound and a halt opcode.
module fetch_controller #(
  parameter int                 ADDR_W      = 7,
  parameter int                 DATA_W      = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [DATA_W-1:0]  HALT_OPCODE = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_WAIT_ACK,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic              capture_en;

  assign pc_inc     = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  // a redirect during CAPTURE discards the word arriving from memory
  assign capture_en = (state == S_CAPTURE) && !redirect_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_HALT: begin
        if (start) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = redirect_valid ? S_ISSUE : S_CAPTURE;
      end
      S_CAPTURE: begin
        state_nxt = redirect_valid ? S_ISSUE : S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // redirect outranks both acceptance and halt detection
        if (redirect_valid) begin
          state_nxt = S_ISSUE;
        end else if (instr_ready) begin
          state_nxt = (instr_out == HALT_OPCODE) ? S_HALT : S_ISSUE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr = pc;
    halted   = (state == S_HALT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= redirect_addr;
      end else if (state == S_CAPTURE) begin
        pc <= pc_inc;
      end

      if (capture_en) begin
        instr_valid <= 1'b1;
        instr_out   <= mem_data;
        instr_pc    <= pc;
      end else if (redirect_valid || ((state == S_WAIT_ACK) && instr_ready)) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule
